// File: rtl/schmidl_cox_peak_detector_pkg.sv
// Shared types and default widths for the Schmidl-Cox peak detector and the metric calculator.
package sc_pkg;

  localparam int SC_WIDTH  = 32;
  localparam int SC_IDX_W  = 16;
  localparam int SC_HOLD_W = 16;

  typedef enum logic [1:0] {
    SC_SEARCH  = 2'd0,
    SC_TRACK   = 2'd1,
    SC_HOLDOFF = 2'd2
  } sc_state_t;

endpackage

// File: rtl/schmidl_cox_peak_detector_argmax.sv
// Running maximum / argmax register pair; exposes next-state values so a firing beat sees itself.
module sc_argmax #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             update_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [WIDTH-1:0] max_next_o,
  output logic [IDX_W-1:0] idx_next_o
);

  logic [WIDTH-1:0] max_q, max_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Strict compare keeps the first occurrence on ties.
  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    if (load_i) begin
      max_d = data_i;
      idx_d = idx_i;
    end else if (update_i && (data_i > max_q)) begin
      max_d = data_i;
      idx_d = idx_i;
    end else begin
      max_d = max_q;
      idx_d = idx_q;
    end
  end

  // Max/argmax state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= {WIDTH{1'b0}};
      idx_q <= {IDX_W{1'b0}};
    end else if (clear_i) begin
      max_q <= {WIDTH{1'b0}};
      idx_q <= {IDX_W{1'b0}};
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end

  assign max_next_o = max_d;
  assign idx_next_o = idx_d;

endmodule

// File: rtl/schmidl_cox_peak_detector.sv
// Finds above-threshold regions in the |P(d)|^2 stream and emits one peak event per region.
// Define SCHMIDL_COX_PEAK_MIDPOINT_EN to report the plateau midpoint instead of the argmax.
module schmidl_cox_peak_detector
  import sc_pkg::*;
#(
  parameter int WIDTH  = SC_WIDTH,
  parameter int IDX_W  = SC_IDX_W,
  parameter int HOLD_W = SC_HOLD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [WIDTH-1:0]  threshold,
  input  logic [HOLD_W-1:0] max_track,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic [WIDTH-1:0]  i_tdata,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic [IDX_W-1:0]  o_index,
  output logic [WIDTH-1:0]  o_peak,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready
);

  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};

  sc_state_t         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [HOLD_W-1:0] trk_q, trk_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              o_tvalid_q, o_tvalid_d;
  logic [IDX_W-1:0]  o_index_q, o_index_d;
  logic [WIDTH-1:0]  o_peak_q, o_peak_d;
  logic              o_tlast_q, o_tlast_d;

  logic              beat_s, above_s, fire_s, load_s, update_s;
  logic [WIDTH-1:0]  max_next_s;
  logic [IDX_W-1:0]  arg_idx_next_s, peak_idx_s;

  assign beat_s   = i_tvalid && !o_tvalid_q;
  assign above_s  = i_tdata > threshold;
  assign load_s   = beat_s && (state_q == SC_SEARCH) && above_s;
  assign update_s = beat_s && (state_q == SC_TRACK);

  sc_argmax #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_argmax (
    .clk        (clk),
    .rst_n      (reset),
    .clear_i    (clear),
    .load_i     (load_s),
    .update_i   (update_s),
    .data_i     (i_tdata),
    .idx_i      (idx_q),
    .max_next_o (max_next_s),
    .idx_next_o (arg_idx_next_s)
  );

`ifdef SCHMIDL_COX_PEAK_MIDPOINT_EN
  logic [IDX_W-1:0] first_q, first_d, last_q, last_d;
  logic [IDX_W:0]   mid_sum_s;

  // Plateau bounds; a region never wraps because i_tlast closes it.
  always_comb begin
    first_d = first_q;
    last_d  = last_q;
    if (load_s) begin
      first_d = idx_q;
      last_d  = idx_q;
    end else if (update_s && above_s) begin
      last_d = idx_q;
    end else begin
      last_d = last_q;
    end
    mid_sum_s  = {1'b0, first_d} + {1'b0, last_d};
    peak_idx_s = IDX_W'(mid_sum_s >> 1);
  end

  // Plateau bound registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_q <= IDX_ZERO;
      last_q  <= IDX_ZERO;
    end else if (clear) begin
      first_q <= IDX_ZERO;
      last_q  <= IDX_ZERO;
    end else begin
      first_q <= first_d;
      last_q  <= last_d;
    end
  end
`else
  assign peak_idx_s = arg_idx_next_s;
`endif

  // Region FSM, sample index, counters and event capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    trk_d      = trk_q;
    hold_d     = hold_q;
    o_tvalid_d = o_tvalid_q;
    o_index_d  = o_index_q;
    o_peak_d   = o_peak_q;
    o_tlast_d  = o_tlast_q;
    fire_s     = 1'b0;

    if (o_tvalid_q && o_tready) begin
      o_tvalid_d = 1'b0;
    end else begin
      o_tvalid_d = o_tvalid_q;
    end

    if (beat_s) begin
      idx_d = i_tlast ? IDX_ZERO : (idx_q + IDX_ONE);
      case (state_q)
        SC_SEARCH: begin
          if (above_s) begin
            trk_d = HOLD_ONE;
            if (i_tlast || (max_track == HOLD_ONE)) begin
              fire_s = 1'b1;
            end else begin
              state_d = SC_TRACK;
            end
          end else begin
            trk_d = HOLD_ZERO;
          end
        end
        SC_TRACK: begin
          trk_d = trk_q + HOLD_ONE;
          if (!above_s || i_tlast || ((max_track != HOLD_ZERO) && (trk_d == max_track))) begin
            fire_s = 1'b1;
          end else begin
            fire_s = 1'b0;
          end
        end
        SC_HOLDOFF: begin
          if (i_tlast || (hold_q <= HOLD_ONE)) begin
            state_d = SC_SEARCH;
            hold_d  = HOLD_ZERO;
          end else begin
            hold_d = hold_q - HOLD_ONE;
          end
        end
        default: begin
          state_d = SC_SEARCH;
          trk_d   = HOLD_ZERO;
          hold_d  = HOLD_ZERO;
        end
      endcase
    end else begin
      idx_d = idx_q;
    end

    if (fire_s) begin
      o_tvalid_d = 1'b1;
      o_index_d  = peak_idx_s;
      o_peak_d   = max_next_s;
      o_tlast_d  = i_tlast;
      trk_d      = HOLD_ZERO;
      if (holdoff == HOLD_ZERO) begin
        state_d = SC_SEARCH;
        hold_d  = HOLD_ZERO;
      end else begin
        state_d = SC_HOLDOFF;
        hold_d  = holdoff;
      end
    end else begin
      o_tlast_d = o_tlast_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SC_SEARCH;
      idx_q      <= IDX_ZERO;
      trk_q      <= HOLD_ZERO;
      hold_q     <= HOLD_ZERO;
      o_tvalid_q <= 1'b0;
      o_index_q  <= IDX_ZERO;
      o_peak_q   <= {WIDTH{1'b0}};
      o_tlast_q  <= 1'b0;
    end else if (clear) begin
      state_q    <= SC_SEARCH;
      idx_q      <= IDX_ZERO;
      trk_q      <= HOLD_ZERO;
      hold_q     <= HOLD_ZERO;
      o_tvalid_q <= 1'b0;
      o_index_q  <= IDX_ZERO;
      o_peak_q   <= {WIDTH{1'b0}};
      o_tlast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      trk_q      <= trk_d;
      hold_q     <= hold_d;
      o_tvalid_q <= o_tvalid_d;
      o_index_q  <= o_index_d;
      o_peak_q   <= o_peak_d;
      o_tlast_q  <= o_tlast_d;
    end
  end

  assign i_tready = !o_tvalid_q;
  assign o_tvalid = o_tvalid_q;
  assign o_index  = o_index_q;
  assign o_peak   = o_peak_q;
  assign o_tlast  = o_tlast_q;

endmodule

// File: tb/tb_schmidl_cox_peak_detector.sv
// Directed self-checking bench for schmidl_cox_peak_detector (honours SCHMIDL_COX_PEAK_MIDPOINT_EN).
module tb_schmidl_cox_peak_detector;

  localparam int WIDTH  = 32;
  localparam int IDX_W  = 16;
  localparam int HOLD_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              clear = 1'b0;
  logic [WIDTH-1:0]  threshold = 32'd100;
  logic [HOLD_W-1:0] max_track = 16'd0;
  logic [HOLD_W-1:0] holdoff = 16'd0;
  logic [WIDTH-1:0]  i_tdata = 32'd0;
  logic              i_tlast = 1'b0;
  logic              i_tvalid = 1'b0;
  logic              i_tready;
  logic [IDX_W-1:0]  o_index;
  logic [WIDTH-1:0]  o_peak;
  logic              o_tlast;
  logic              o_tvalid;
  logic              o_tready = 1'b0;

  int checks = 0;
  int errors = 0;

  schmidl_cox_peak_detector #(.WIDTH(WIDTH), .IDX_W(IDX_W), .HOLD_W(HOLD_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .threshold (threshold),
    .max_track (max_track),
    .holdoff   (holdoff),
    .i_tdata   (i_tdata),
    .i_tlast   (i_tlast),
    .i_tvalid  (i_tvalid),
    .i_tready  (i_tready),
    .o_index   (o_index),
    .o_peak    (o_peak),
    .o_tlast   (o_tlast),
    .o_tvalid  (o_tvalid),
    .o_tready  (o_tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One input beat: wait (bounded) for i_tready, then present it across one rising edge.
  task automatic send(input logic [WIDTH-1:0] data, input logic last);
    int n;
    i_tdata  = data;
    i_tlast  = last;
    i_tvalid = 1'b1;
    n = 0;
    while (!i_tready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!i_tready) check("send_ready_timeout", 64'(i_tready), 64'd1);
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  // Event must be present right after the firing beat; accept it and confirm deassertion.
  task automatic take_event(input string tag, input logic [IDX_W-1:0] eidx,
                            input logic [WIDTH-1:0] epeak, input logic etlast);
    check({tag, "_valid"}, 64'(o_tvalid), 64'd1);
    check({tag, "_index"}, 64'(o_index), 64'(eidx));
    check({tag, "_peak"},  64'(o_peak),  64'(epeak));
    check({tag, "_tlast"}, 64'(o_tlast), 64'(etlast));
    o_tready = 1'b1;
    @(posedge clk); #1;
    o_tready = 1'b0;
    check({tag, "_drop"}, 64'(o_tvalid), 64'd0);
  endtask

  initial begin
    logic [IDX_W-1:0] exp3a;
    logic [IDX_W-1:0] exp3b;
`ifdef SCHMIDL_COX_PEAK_MIDPOINT_EN
    exp3a = 16'd1;
    exp3b = 16'd7;
`else
    exp3a = 16'd0;
    exp3b = 16'd6;
`endif

    // Reset state
    #12;
    check("rst_valid", 64'(o_tvalid), 64'd0);
    check("rst_index", 64'(o_index), 64'd0);
    check("rst_peak",  64'(o_peak), 64'd0);
    check("rst_ready", 64'(i_tready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;

    // Test 1: basic region, fires on the first sub-threshold beat
    send(32'd0, 1'b0); send(32'd50, 1'b0); send(32'd150, 1'b0);
    send(32'd300, 1'b0); send(32'd200, 1'b0);
    check("t1_no_early_event", 64'(o_tvalid), 64'd0);
    send(32'd90, 1'b0);
    check("t1_stall_ready", 64'(i_tready), 64'd0);
    take_event("t1", 16'd3, 32'd300, 1'b0);
    send(32'd0, 1'b1);

    // Test 2: tie keeps the first maximum
    send(32'd0, 1'b0); send(32'd200, 1'b0); send(32'd200, 1'b0); send(32'd50, 1'b0);
    take_event("t2", 16'd1, 32'd200, 1'b0);
    send(32'd0, 1'b1);

    // Test 3: max_track forces events, holdoff skips two beats
    max_track = 16'd4;
    holdoff   = 16'd2;
    for (int i = 0; i < 4; i++) send(32'd500, 1'b0);
    take_event("t3a", exp3a, 32'd500, 1'b0);
    for (int i = 4; i < 9; i++) send(32'd500, 1'b0);
    check("t3_mid_region", 64'(o_tvalid), 64'd0);
    send(32'd500, 1'b0);
    take_event("t3b", exp3b, 32'd500, 1'b0);
    send(32'd0, 1'b1);
    max_track = 16'd0;
    holdoff   = 16'd0;

    // Test 4: region truncated by i_tlast, then single-beat region restarts at index 0
    send(32'd150, 1'b0); send(32'd250, 1'b0); send(32'd250, 1'b1);
    take_event("t4a", 16'd1, 32'd250, 1'b1);
    send(32'd300, 1'b1);
    take_event("t4b", 16'd0, 32'd300, 1'b1);

    // Test 5: event held under backpressure while a beat waits upstream
    send(32'd0, 1'b0); send(32'd400, 1'b0); send(32'd0, 1'b0);
    i_tdata  = 32'd999;
    i_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t5_hold_valid", 64'(o_tvalid), 64'd1);
      check("t5_hold_index", 64'(o_index), 64'd1);
      check("t5_hold_peak",  64'(o_peak), 64'd400);
      check("t5_hold_ready", 64'(i_tready), 64'd0);
    end
    o_tready = 1'b1;
    @(posedge clk); #1;
    o_tready = 1'b0;
    check("t5_drop", 64'(o_tvalid), 64'd0);
    check("t5_ready_back", 64'(i_tready), 64'd1);
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    send(32'd0, 1'b1);
    take_event("t5b", 16'd3, 32'd999, 1'b1);

    // Test 6a: asynchronous reset mid-TRACK
    send(32'd500, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check("t6_rst_index", 64'(o_index), 64'd0);
    check("t6_rst_peak",  64'(o_peak), 64'd0);
    check("t6_rst_tlast", 64'(o_tlast), 64'd0);
    check("t6_rst_valid", 64'(o_tvalid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    send(32'd0, 1'b0); send(32'd0, 1'b0); send(32'd300, 1'b0); send(32'd0, 1'b0);
    take_event("t6a", 16'd2, 32'd300, 1'b0);

    // Test 6b: clear drops the concurrent beat and zeroes outputs and index
    i_tdata  = 32'd700;
    i_tvalid = 1'b1;
    clear    = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
    i_tvalid = 1'b0;
    check("t6_clr_peak",  64'(o_peak), 64'd0);
    check("t6_clr_index", 64'(o_index), 64'd0);
    send(32'd0, 1'b0); send(32'd600, 1'b0); send(32'd0, 1'b0);
    take_event("t6b", 16'd1, 32'd600, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
